// File: rtl/amax10_qsys_nios2_gen2_oci_trace_capture_pkg.sv
// Shared definitions for the OCI trace capture buffer: state encoding and
// entry width helper.
package amax10_qsys_oci_trace_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_POST    = 3'd2,
        ST_DONE    = 3'd3
    } trace_state_e;

    function automatic int unsigned entry_width(input int unsigned count_w,
                                                input int unsigned data_w);
        return count_w + data_w;
    endfunction

endpackage

// File: rtl/amax10_qsys_nios2_gen2_oci_trace_capture_if.sv
// Capture/readback signal bundle for the OCI trace capture buffer.
interface amax10_qsys_nios2_gen2_oci_trace_capture_if #(
    parameter int unsigned DATA_W  = 30,
    parameter int unsigned COUNT_W = 4,
    parameter int unsigned DEPTH   = 16
);
    import amax10_qsys_oci_trace_pkg::*;

    localparam int unsigned ENTRY_W = entry_width(COUNT_W, DATA_W);
    localparam int unsigned LEVEL_W = $clog2(DEPTH) + 1;

    logic                 arm;
    logic                 dct_valid;
    logic [DATA_W-1:0]    dct_buffer;
    logic [COUNT_W-1:0]   dct_count;
    logic                 test_ending;
    logic                 test_has_ended;
    logic                 rd_req;
    logic                 rd_valid;
    logic [ENTRY_W-1:0]   rd_data;
    logic                 rd_empty;
    logic [LEVEL_W-1:0]   level;
    logic                 overflow;
    logic                 done;
    logic [STATE_W-1:0]   state_o;

    modport slave (
        input  arm, dct_valid, dct_buffer, dct_count,
               test_ending, test_has_ended, rd_req,
        output rd_valid, rd_data, rd_empty, level, overflow, done, state_o
    );

    modport master (
        output arm, dct_valid, dct_buffer, dct_count,
               test_ending, test_has_ended, rd_req,
        input  rd_valid, rd_data, rd_empty, level, overflow, done, state_o
    );

endinterface

// File: rtl/amax10_qsys_nios2_gen2_oci_trace_capture_ram.sv
// Simple dual-port trace RAM with a registered read port (1-cycle latency).
module amax10_qsys_oci_trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is cleared; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/amax10_qsys_nios2_gen2_oci_trace_capture.sv
// Circular capture buffer for Nios II OCI DCT trace words with post-trigger
// capture, hard-stop freeze and ordered readback once DONE.
module amax10_qsys_nios2_gen2_oci_trace_capture
    import amax10_qsys_oci_trace_pkg::*;
#(
    parameter int unsigned DATA_W     = 30,
    parameter int unsigned COUNT_W    = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned WRAP_MODE  = 1,
    parameter int unsigned POST_COUNT = 4
) (
    input  logic clk,
    input  logic reset,
    amax10_qsys_nios2_gen2_oci_trace_capture_if.slave bus
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned PW      = AW;
    localparam int unsigned ENTRY_W = entry_width(COUNT_W, DATA_W);

    trace_state_e   state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [PW-1:0]  post_q, post_d;
    logic           overflow_q, overflow_d;
    logic           rd_valid_q, rd_valid_d;

    logic           accept;
    logic           full;
    logic           ram_we;
    logic           ram_re;
    logic [ENTRY_W-1:0] ram_rdata;

    assign accept = bus.dct_valid && (bus.dct_count != '0);
    assign full   = (level_q == LW'(DEPTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            post_q     <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            post_q     <= post_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        post_d     = post_q;
        overflow_d = overflow_q;
        rd_valid_d = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        if (bus.arm) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            post_d     = '0;
            overflow_d = 1'b0;
            state_d    = ST_CAPTURE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_CAPTURE, ST_POST: begin
                    // The entry of the cycle that triggers DONE is still stored.
                    if (accept) begin
                        if (!full) begin
                            ram_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + AW'(1);
                            level_d  = level_q + LW'(1);
                        end else if (WRAP_MODE != 0) begin
                            ram_we     = 1'b1;
                            wr_ptr_d   = wr_ptr_q + AW'(1);
                            rd_ptr_d   = rd_ptr_q + AW'(1);
                            overflow_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end

                    if (bus.test_has_ended) begin
                        state_d = ST_DONE;
                    end else if (state_q == ST_CAPTURE) begin
                        if (bus.test_ending) begin
                            post_d  = PW'(POST_COUNT);
                            state_d = (POST_COUNT == 0) ? ST_DONE : ST_POST;
                        end
                    end else if (accept) begin
                        post_d = post_q - PW'(1);
                        if (post_q == PW'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.rd_req && (level_q != '0)) begin
                        ram_re     = 1'b1;
                        rd_ptr_d   = rd_ptr_q + AW'(1);
                        level_d    = level_q - LW'(1);
                        rd_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    amax10_qsys_oci_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata ({bus.dct_count, bus.dct_buffer}),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = ram_rdata;
    assign bus.rd_empty = (level_q == '0);
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.done     = (state_q == ST_DONE);
    assign bus.state_o  = state_q;

endmodule

// File: tb/tb_amax10_qsys_nios2_gen2_oci_trace_capture.sv
// Directed bench: a wrapping and a non-wrapping DEPTH=8 instance share stimulus
// and are checked each cycle against a queue-based reference model.
module tb_amax10_qsys_nios2_gen2_oci_trace_capture;

    localparam int unsigned DW    = 30;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEP   = 8;
    localparam int unsigned POSTN = 4;

    typedef logic [CW+DW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          arm, dv, te, the, rd;
    logic [CW-1:0] cnt;
    logic [DW-1:0] pay;

    int n_assert = 0;
    int n_fail   = 0;

    ent_t q0[$];
    ent_t q1[$];
    bit   ovf0, ovf1;
    bit   rdv0, rdv1;
    ent_t rdd0, rdd1;
    int   mstate;
    int   mpost;

    always #5 clk = ~clk;

    amax10_qsys_nios2_gen2_oci_trace_capture_if #(.DATA_W(DW), .COUNT_W(CW), .DEPTH(DEP)) ifa ();
    amax10_qsys_nios2_gen2_oci_trace_capture_if #(.DATA_W(DW), .COUNT_W(CW), .DEPTH(DEP)) ifb ();

    assign ifa.arm = arm;  assign ifa.dct_valid = dv;  assign ifa.dct_buffer = pay;
    assign ifa.dct_count = cnt;  assign ifa.test_ending = te;
    assign ifa.test_has_ended = the;  assign ifa.rd_req = rd;
    assign ifb.arm = arm;  assign ifb.dct_valid = dv;  assign ifb.dct_buffer = pay;
    assign ifb.dct_count = cnt;  assign ifb.test_ending = te;
    assign ifb.test_has_ended = the;  assign ifb.rd_req = rd;

    amax10_qsys_nios2_gen2_oci_trace_capture #(
        .DATA_W(DW), .COUNT_W(CW), .DEPTH(DEP), .WRAP_MODE(1), .POST_COUNT(POSTN)
    ) u_wrap (
        .clk(clk), .reset(reset), .bus(ifa.slave)
    );

    amax10_qsys_nios2_gen2_oci_trace_capture #(
        .DATA_W(DW), .COUNT_W(CW), .DEPTH(DEP), .WRAP_MODE(0), .POST_COUNT(POSTN)
    ) u_nowrap (
        .clk(clk), .reset(reset), .bus(ifb.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string pfx, input logic [2:0] st, input logic [3:0] lvl,
                             input logic ov, input logic dn, input logic emp,
                             input logic rv, input ent_t rdat,
                             input int exp_lvl, input bit exp_ov, input bit exp_rv,
                             input ent_t exp_rd);
        chk({pfx, ".state"}, 64'(st), 64'(mstate));
        chk({pfx, ".level"}, 64'(lvl), 64'(exp_lvl));
        chk({pfx, ".overflow"}, 64'(ov), 64'(exp_ov));
        chk({pfx, ".done"}, 64'(dn), 64'(mstate == 3));
        chk({pfx, ".rd_empty"}, 64'(emp), 64'(exp_lvl == 0));
        chk({pfx, ".rd_valid"}, 64'(rv), 64'(exp_rv));
        if (exp_rv) chk({pfx, ".rd_data"}, 64'(rdat), 64'(exp_rd));
    endtask

    task automatic check_all();
        check_dut("wrap", ifa.state_o, ifa.level, ifa.overflow, ifa.done, ifa.rd_empty,
                  ifa.rd_valid, ifa.rd_data, q0.size(), ovf0, rdv0, rdd0);
        check_dut("nowrap", ifb.state_o, ifb.level, ifb.overflow, ifb.done, ifb.rd_empty,
                  ifb.rd_valid, ifb.rd_data, q1.size(), ovf1, rdv1, rdd1);
    endtask

    task automatic model_write(input ent_t e);
        if (q0.size() == DEP) begin
            void'(q0.pop_front());
            ovf0 = 1'b1;
        end
        q0.push_back(e);
        if (q1.size() == DEP) ovf1 = 1'b1;
        else q1.push_back(e);
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        ovf0 = 1'b0;
        ovf1 = 1'b0;
        mpost = 0;
    endtask

    // One clock with the given inputs; the model reflects the edge, then both DUTs are checked.
    task automatic step(input bit a, input bit v, input int c, input int p,
                        input bit te_i, input bit the_i, input bit rd_i);
        bit acc;
        arm = a; dv = v; cnt = CW'(c); pay = DW'(p); te = te_i; the = the_i; rd = rd_i;
        @(posedge clk);
        acc  = v && (c != 0);
        rdv0 = 1'b0;
        rdv1 = 1'b0;
        if (a) begin
            model_clear();
            mstate = 1;
        end else if (mstate == 1 || mstate == 2) begin
            if (acc) model_write({CW'(c), DW'(p)});
            if (the_i) begin
                mstate = 3;
            end else if (mstate == 1) begin
                if (te_i) begin
                    mpost  = POSTN;
                    mstate = (POSTN == 0) ? 3 : 2;
                end
            end else if (acc) begin
                mpost--;
                if (mpost == 0) mstate = 3;
            end
        end else if (mstate == 3 && rd_i) begin
            if (q0.size() > 0) begin rdd0 = q0.pop_front(); rdv0 = 1'b1; end
            if (q1.size() > 0) begin rdd1 = q1.pop_front(); rdv1 = 1'b1; end
        end
        #1;
        check_all();
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic entry(input int p); step(0, 1, 1, p, 0, 0, 0); endtask
    task automatic read(); step(0, 0, 0, 0, 0, 0, 1); endtask

    task automatic do_reset();
        reset = 1'b1;
        arm = 0; dv = 0; cnt = '0; pay = '0; te = 0; the = 0; rd = 0;
        @(posedge clk);
        model_clear();
        mstate = 0;
        rdv0 = 1'b0;
        rdv1 = 1'b0;
        #1;
        check_all();
        chk("wrap.rd_data_reset", 64'(ifa.rd_data), 64'd0);
        chk("nowrap.rd_data_reset", 64'(ifb.rd_data), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        arm = 0; dv = 0; cnt = '0; pay = '0; te = 0; the = 0; rd = 0;
        mstate = 0; rdv0 = 0; rdv1 = 0; rdd0 = '0; rdd1 = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // IDLE ignores entries and reads
        step(0, 1, 1, 77, 0, 0, 1);

        // Basic capture, hard stop, ordered readback, empty read
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) entry(i);
        step(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) read();

        // Overfill: wrap keeps newest 8, no-wrap keeps oldest 8
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 11; i++) entry(i);
        step(0, 1, 1, 12, 0, 1, 0);
        for (int i = 0; i < 9; i++) read();

        // No-op entries and reads during CAPTURE, then post-trigger capture
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 99, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) entry(i);
        step(0, 1, 1, 4, 1, 0, 0);
        entry(5);
        step(0, 1, 1, 6, 1, 0, 0);
        for (int i = 7; i <= 10; i++) entry(i);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) read();

        // Arm wins over hard stop; reset mid-POST with level 6
        step(1, 1, 1, 50, 0, 1, 0);
        for (int i = 1; i <= 3; i++) entry(i);
        step(0, 1, 1, 4, 1, 0, 0);
        entry(5);
        entry(6);
        do_reset();
        idle();

        // Clean restart with wide payloads and non-unit counts
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 15, 32'h3FFF_FFFF, 0, 0, 0);
        step(0, 1, 5, 32'h1234_5678, 0, 0, 0);
        step(0, 1, 9, 32'h2AAA_AAAA, 0, 1, 0);
        step(0, 1, 3, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) read();
        step(1, 0, 0, 0, 0, 0, 1);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/amax10_qsys_nios2_gen2_oci_trace_capture.md
Name: amax10_qsys_nios2_gen2_oci_trace_capture

Overview:
Parametrised capture buffer for Nios II OCI debug-trace (DCT) words; successor to the input-only OCI test-bench sink. Stores {dct_count, dct_buffer} entries in a circular RAM, applies post-trigger capture on test_ending, freezes on test_has_ended, then allows ordered readback. Sits beside the nios2_gen2 OCI block in simulation and debug builds.

Parameters:
DATA_W, 30, width of dct_buffer
COUNT_W, 4, width of dct_count
DEPTH, 16, entries in trace RAM (power of 2, >=4)
WRAP_MODE, 1, 1 = overwrite oldest when full; 0 = stop writing when full
POST_COUNT, 4, entries still captured after test_ending (0..DEPTH-1)

Ports:
clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
arm  in  1  pulse: clear buffer, enter CAPTURE
dct_valid  in  1  dct_buffer/dct_count valid this cycle
dct_buffer  in  DATA_W  trace payload
dct_count  in  COUNT_W  payload slot count; 0 = no-op entry, never stored
test_ending  in  1  trigger: start post-trigger countdown
test_has_ended  in  1  hard stop: freeze immediately
rd_req  in  1  pop oldest entry (honoured only in DONE, not empty)
rd_valid  out  1  rd_data valid, one cycle after accepted rd_req
rd_data  out  COUNT_W+DATA_W  {count, payload}
rd_empty  out  1  level == 0
level  out  $clog2(DEPTH)+1  stored entries
overflow  out  1  sticky: an entry was lost or overwritten
done  out  1  state == DONE
state_o  out  3  IDLE=0, CAPTURE=1, POST=2, DONE=3

Behaviour:
- Reset: state IDLE; wr_ptr, rd_ptr, level, post counter = 0; rd_valid, overflow, done = 0; rd_data = 0; rd_empty = 1. RAM contents not reset.
- Accept = dct_valid & (dct_count != 0) in CAPTURE or POST.
- IDLE: ignores dct inputs; arm -> CAPTURE.
- CAPTURE: accepted entry written at wr_ptr, wr_ptr+1 mod DEPTH, level+1 (saturating at DEPTH). Full and WRAP_MODE=1: overwrite, rd_ptr+1, overflow=1. Full and WRAP_MODE=0: drop, overflow=1.
- test_ending in CAPTURE: load counter = POST_COUNT; POST_COUNT=0 -> DONE next cycle, and the entry accepted in the trigger cycle is still stored.
- POST: each accepted entry decrements counter; reaching 0 on a write -> DONE, that entry stored. Further test_ending ignored.
- test_has_ended in CAPTURE/POST: -> DONE; a same-cycle entry is stored. Takes priority over test_ending.
- arm in any state: clear pointers, level, overflow; -> CAPTURE. Priority arm > test_has_ended > test_ending. A same-cycle dct entry is discarded.
- DONE: no writes. rd_req with level>0: rd_data <= RAM[rd_ptr], rd_valid=1 next cycle, rd_ptr+1, level-1. rd_req when empty: ignored, rd_valid=0. Back-to-back reads at 1/cycle.
- rd_req outside DONE ignored. rd_valid is a single-cycle pulse per accepted read.
- Pointer wrap: mod DEPTH via power-of-2 truncation; level is the separate full/empty discriminator.

Decomposition:
- Shared package amax10_qsys_oci_trace_pkg: state encoding constants, entry width function (COUNT_W+DATA_W).
- Sub-module amax10_qsys_oci_trace_ram: simple dual-port RAM, DEPTH x entry width, registered read (1-cycle latency), inferable as M9K.

Test Plan:
- DEPTH=8, arm, 5 entries (payload 1..5, count 1), test_has_ended -> done=1, level=5; 5 reads return 1..5 in order; rd_empty=1; overflow=0.
- WRAP_MODE=1, 11 entries (1..11), test_has_ended -> level=8, overflow=1; reads return 4..11.
- WRAP_MODE=0, 11 entries -> level=8, overflow=1; reads return 1..8.
- POST_COUNT=4: 3 entries, test_ending with entry 4 in the same cycle, then entries 5..10 -> DONE after entry 8; level=8; entries 9,10 absent.
- dct_count=0 with dct_valid, plus rd_req during CAPTURE -> level unchanged, rd_valid stays 0.
- Reset asserted mid-POST with level=6 -> next cycle state_o=0, level=0, overflow=0, done=0, rd_empty=1; arm restarts capture cleanly.
